// File: rtl/gpio_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported GPIO memory.
// Registers one command per cycle and tracks reads through a 2-stage pipeline.
module gpio_port_arbiter #(
   parameter int unsigned RO_LO = 503,
   parameter int unsigned RO_HI = 505
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic       we0,
   input  logic       we1,
   input  logic [8:0] addr0,
   input  logic [8:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       rvalid0,
   output logic       rvalid1,
   output logic [7:0] rdata,
   output logic       wr_err0,
   output logic       wr_err1,
   output logic       mem_rw_select,
   output logic [8:0] mem_address,
   output logic [7:0] mem_data_in,
   input  logic [7:0] mem_data_out
);

   localparam logic [8:0] RoLo = 9'(RO_LO);
   localparam logic [8:0] RoHi = 9'(RO_HI);

   logic       last_winner_q, last_winner_d;
   logic       mem_rw_select_q, mem_rw_select_d;
   logic [8:0] mem_address_q, mem_address_d;
   logic [7:0] mem_data_in_q, mem_data_in_d;
   logic       wr_err0_q, wr_err0_d;
   logic       wr_err1_q, wr_err1_d;
   logic       s1_vld_q, s1_vld_d;
   logic       s1_port_q, s1_port_d;
   logic       s2_vld_q, s2_vld_d;
   logic       s2_port_q, s2_port_d;

   logic       any_gnt;
   logic       sel_we;
   logic [8:0] sel_addr;
   logic [7:0] sel_wdata;
   logic       ro_hit;

   always_comb begin
      // last_winner_q = 1 means port 1 won last, so port 0 takes the tie.
      gnt0      = rst_n & req0 & (~req1 | last_winner_q);
      gnt1      = rst_n & req1 & (~req0 | ~last_winner_q);
      any_gnt   = gnt0 | gnt1;
      sel_we    = gnt1 ? we1 : we0;
      sel_addr  = gnt1 ? addr1 : addr0;
      sel_wdata = gnt1 ? wdata1 : wdata0;
      ro_hit    = sel_we && (sel_addr >= RoLo) && (sel_addr <= RoHi);

      last_winner_d   = any_gnt ? gnt1 : last_winner_q;
      mem_rw_select_d = any_gnt & sel_we & ~ro_hit;
      mem_address_d   = any_gnt ? sel_addr : mem_address_q;
      mem_data_in_d   = any_gnt ? sel_wdata : mem_data_in_q;
      wr_err0_d       = gnt0 & ro_hit;
      wr_err1_d       = gnt1 & ro_hit;
      s1_vld_d        = any_gnt & ~sel_we;
      s1_port_d       = gnt1;
      s2_vld_d        = s1_vld_q;
      s2_port_d       = s1_port_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_winner_q   <= 1'b1;
         mem_rw_select_q <= 1'b0;
         mem_address_q   <= '0;
         mem_data_in_q   <= '0;
         wr_err0_q       <= 1'b0;
         wr_err1_q       <= 1'b0;
         s1_vld_q        <= 1'b0;
         s1_port_q       <= 1'b0;
         s2_vld_q        <= 1'b0;
         s2_port_q       <= 1'b0;
      end else begin
         last_winner_q   <= last_winner_d;
         mem_rw_select_q <= mem_rw_select_d;
         mem_address_q   <= mem_address_d;
         mem_data_in_q   <= mem_data_in_d;
         wr_err0_q       <= wr_err0_d;
         wr_err1_q       <= wr_err1_d;
         s1_vld_q        <= s1_vld_d;
         s1_port_q       <= s1_port_d;
         s2_vld_q        <= s2_vld_d;
         s2_port_q       <= s2_port_d;
      end
   end

   always_comb begin
      mem_rw_select = mem_rw_select_q;
      mem_address   = mem_address_q;
      mem_data_in   = mem_data_in_q;
      wr_err0       = wr_err0_q;
      wr_err1       = wr_err1_q;
      rvalid0       = s2_vld_q & ~s2_port_q;
      rvalid1       = s2_vld_q & s2_port_q;
      rdata         = mem_data_out;
   end

endmodule

// File: tb/tb_gpio_port_arbiter.sv
// Directed bench for gpio_port_arbiter with a behavioural 512 x 8 memory.
module tb_gpio_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, we0, we1;
   logic [8:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1, wr_err0, wr_err1;
   logic [7:0] rdata;
   logic       mem_rw_select;
   logic [8:0] mem_address;
   logic [7:0] mem_data_in;
   logic [7:0] mem_data_out = 8'h00;
   logic [7:0] mem [512];

   int n_vec  = 0;
   int n_miss = 0;

   gpio_port_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0         (req0),
      .req1         (req1),
      .we0          (we0),
      .we1          (we1),
      .addr0        (addr0),
      .addr1        (addr1),
      .wdata0       (wdata0),
      .wdata1       (wdata1),
      .gnt0         (gnt0),
      .gnt1         (gnt1),
      .rvalid0      (rvalid0),
      .rvalid1      (rvalid1),
      .rdata        (rdata),
      .wr_err0      (wr_err0),
      .wr_err1      (wr_err1),
      .mem_rw_select(mem_rw_select),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rw_select) mem[mem_address] <= mem_data_in;
      mem_data_out <= mem[mem_address];
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int p, input logic we, input logic [8:0] a, input logic [7:0] d);
      if (p == 0) begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end
   endtask

   task automatic idle_req();
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // One isolated transfer from port p, checked over grant, command and return cycles.
   task automatic xfer(input int p, input logic we, input logic [8:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd);
      logic ro;
      logic wr_ok;
      ro    = we && (a >= 9'd503) && (a <= 9'd505);
      wr_ok = we && !ro;
      next_cycle();
      drive(p, we, a, d);
      @(negedge clk);
      check("xfer_gnt0", 16'(gnt0), 16'(p == 0));
      check("xfer_gnt1", 16'(gnt1), 16'(p == 1));
      next_cycle();
      idle_req();
      @(negedge clk);
      check("xfer_addr", 16'(mem_address), 16'(a));
      check("xfer_rw", 16'(mem_rw_select), 16'(wr_ok));
      if (wr_ok) check("xfer_wdata", 16'(mem_data_in), 16'(d));
      check("xfer_err0", 16'(wr_err0), 16'(ro && p == 0));
      check("xfer_err1", 16'(wr_err1), 16'(ro && p == 1));
      check("xfer_rv_early", 16'({rvalid1, rvalid0}), 16'h0);
      next_cycle();
      @(negedge clk);
      check("xfer_rv0", 16'(rvalid0), 16'(!we && p == 0));
      check("xfer_rv1", 16'(rvalid1), 16'(!we && p == 1));
      if (!we) check("xfer_rdata", 16'(rdata), 16'(exp_rd));
      check("xfer_err_clr", 16'({wr_err1, wr_err0}), 16'h0);
      check("xfer_rw_clr", 16'(mem_rw_select), 16'h0);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'(i);
      mem[508] = 8'h05;
      mem[503] = 8'h11;
      mem[504] = 8'h22;
      mem[505] = 8'h33;
      idle_req();
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      rst_n = 1'b0;
      req0  = 1'b1;
      req1  = 1'b1;
      #2;
      check("rst_gnt", 16'({gnt1, gnt0}), 16'h0);
      check("rst_mem", 16'({mem_rw_select, mem_address}), 16'h0);
      check("rst_wdat", 16'(mem_data_in), 16'h0);
      check("rst_flags", 16'({rvalid1, rvalid0, wr_err1, wr_err0}), 16'h0);
      repeat (2) next_cycle();
      idle_req();
      rst_n = 1'b1;

      // Contention: 6 cycles of both reading, grants alternate starting with port 0.
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         if (i < 6) begin
            drive(0, 1'b0, 9'd503, 8'h00);
            drive(1, 1'b0, 9'd505, 8'h00);
         end else begin
            idle_req();
         end
         @(negedge clk);
         if (i < 6) begin
            check("cont_gnt0", 16'(gnt0), 16'(i % 2 == 0));
            check("cont_gnt1", 16'(gnt1), 16'(i % 2 == 1));
         end
         if (i >= 2) begin
            check("cont_rv0", 16'(rvalid0), 16'(i % 2 == 0));
            check("cont_rv1", 16'(rvalid1), 16'(i % 2 == 1));
            check("cont_rdata", 16'(rdata), (i % 2 == 0) ? 16'h11 : 16'h33);
         end else begin
            check("cont_rv_none", 16'({rvalid1, rvalid0}), 16'h0);
         end
      end

      xfer(0, 1'b0, 9'd508, 8'h00, 8'h05);

      // Write LEDs on port 1, then read-after-write from port 0 in the next cycle.
      next_cycle();
      drive(1, 1'b1, 9'd506, 8'hA5);
      @(negedge clk);
      check("raw_gnt1", 16'({gnt1, gnt0}), 16'h2);
      next_cycle();
      idle_req();
      drive(0, 1'b0, 9'd506, 8'h00);
      @(negedge clk);
      check("raw_wr_rw", 16'(mem_rw_select), 16'h1);
      check("raw_wr_addr", 16'(mem_address), 16'd506);
      check("raw_wr_data", 16'(mem_data_in), 16'hA5);
      check("raw_gnt0", 16'({gnt1, gnt0}), 16'h1);
      next_cycle();
      idle_req();
      @(negedge clk);
      check("raw_rd_rw", 16'(mem_rw_select), 16'h0);
      check("raw_rv_early", 16'({rvalid1, rvalid0}), 16'h0);
      next_cycle();
      @(negedge clk);
      check("raw_rv0", 16'({rvalid1, rvalid0}), 16'h1);
      check("raw_rdata", 16'(rdata), 16'hA5);

      // Read-only window protection and its boundaries.
      xfer(0, 1'b1, 9'd504, 8'hFF, 8'h00);
      xfer(1, 1'b1, 9'd503, 8'hEE, 8'h00);
      xfer(1, 1'b1, 9'd505, 8'hDD, 8'h00);
      xfer(0, 1'b1, 9'd502, 8'h77, 8'h00);
      xfer(1, 1'b0, 9'd504, 8'h00, 8'h22);
      xfer(0, 1'b0, 9'd503, 8'h00, 8'h11);
      xfer(1, 1'b0, 9'd505, 8'h00, 8'h33);
      xfer(1, 1'b0, 9'd502, 8'h00, 8'h77);

      // Reset while a port 1 read is in flight.
      next_cycle();
      drive(1, 1'b0, 9'd508, 8'h00);
      @(negedge clk);
      check("rmid_gnt1", 16'({gnt1, gnt0}), 16'h2);
      next_cycle();
      rst_n = 1'b0;
      @(negedge clk);
      check("rmid_gnt", 16'({gnt1, gnt0}), 16'h0);
      check("rmid_mem", 16'({mem_rw_select, mem_address}), 16'h0);
      check("rmid_flags", 16'({rvalid1, rvalid0, wr_err1, wr_err0}), 16'h0);
      next_cycle();
      drive(0, 1'b0, 9'd508, 8'h00);
      @(negedge clk);
      check("rmid_gnt_held", 16'({gnt1, gnt0}), 16'h0);
      check("rmid_rv", 16'({rvalid1, rvalid0}), 16'h0);
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check("rmid_tie", 16'({gnt1, gnt0}), 16'h1);
      check("rmid_rv_after", 16'({rvalid1, rvalid0}), 16'h0);
      next_cycle();
      idle_req();
      @(negedge clk);
      check("rmid_rv_after2", 16'(rvalid1), 16'h0);
      next_cycle();
      @(negedge clk);
      check("rmid_rv0_tie", 16'({rvalid1, rvalid0}), 16'h1);

      // Idle: nothing moves.
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         @(negedge clk);
         check("idle_out", 16'({gnt1, gnt0, rvalid1, rvalid0, wr_err1, wr_err0, mem_rw_select}),
               16'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
